// File: rtl/daq_frame_checker.sv
// daq_frame_checker: receive-side checker for DAQ test frames
// (HEAD, PAYLOAD_WORDS x {2k+1,2k+2}, TAIL) on the 32-bit host write pipe.
// Ports: bus_clk/bus_rst_n (async, active low); in_open/in_wren/in_data
// stream input, in_full (always 0); clr sync clear; frame_ok/frame_err
// pulses; err_code/err_sticky; ok/err/drop saturating counters; busy;
// cap_* first-mismatch capture, live only with DAQ_CHECK_CAPTURE_EN.
module daq_frame_checker #(
  parameter int unsigned PAYLOAD_WORDS = 24,
  parameter logic [31:0] HEAD_WORD     = 32'hAAAAAAAA,
  parameter logic [31:0] TAIL_WORD     = 32'hF0F0F0F0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             bus_clk,
  input  logic             bus_rst_n,
  input  logic             in_open,
  input  logic             in_wren,
  input  logic [31:0]      in_data,
  output logic             in_full,
  input  logic             clr,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy,
  output logic             cap_valid,
  output logic [7:0]       cap_index,
  output logic [31:0]      cap_expected,
  output logic [31:0]      cap_actual
);

  localparam int unsigned IDX_W =
    (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(PAYLOAD_WORDS - 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PAYLOAD = 2'd1;
  localparam logic [1:0] ERR_TAIL    = 2'd2;
  localparam logic [1:0] ERR_HEAD    = 2'd3;

  typedef enum logic [1:0] {
    S_HUNT,
    S_PAYLOAD,
    S_TAIL
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             bad_q, bad_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [1:0]       new_code;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             accept;
  logic             is_head;
  logic             is_tail;
  logic [15:0]      k16;
  logic [31:0]      exp_word;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept   = in_open && in_wren;
  assign is_head  = (in_data == HEAD_WORD);
  assign is_tail  = (in_data == TAIL_WORD);
  assign k16      = 16'(k_q);
  assign exp_word = {(k16 << 1) + 16'd1, (k16 << 1) + 16'd2};

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    bad_d      = bad_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    new_code   = ERR_NONE;
    code_d     = code_q;
    sticky_d   = sticky_q;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (!in_open) begin
      // closed pipe: abandon any partial frame silently
      state_d = S_HUNT;
      k_d     = '0;
      bad_d   = 1'b0;
    end else if (in_wren) begin
      unique case (state_q)
        S_HUNT: begin
          if (is_head) begin
            state_d = S_PAYLOAD;
            k_d     = '0;
            bad_d   = 1'b0;
          end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
          end
        end
        S_PAYLOAD: begin
          if (is_head) begin
            // early head kills this frame and opens the next
            err_d    = 1'b1;
            new_code = ERR_HEAD;
            k_d      = '0;
            bad_d    = 1'b0;
          end else begin
            if (in_data != exp_word) bad_d = 1'b1;
            if (k_q == K_LAST) state_d = S_TAIL;
            else               k_d     = k_q + 1'b1;
          end
        end
        S_TAIL: begin
          state_d = S_HUNT;
          k_d     = '0;
          unique case (1'b1)
            is_tail && !bad_q: ok_d = 1'b1;
            is_tail && bad_q: begin
              err_d    = 1'b1;
              new_code = ERR_PAYLOAD;
            end
            !is_tail: begin
              err_d    = 1'b1;
              new_code = ERR_TAIL;
            end
          endcase
        end
        default: state_d = S_HUNT;
      endcase
    end

    if (err_d) begin
      code_d    = new_code;
      sticky_d  = 1'b1;
      err_cnt_d = sat_inc(err_cnt_q);
    end
    if (ok_d) ok_cnt_d = sat_inc(ok_cnt_q);

    // clear wins over a same-cycle update; pulses still go out
    if (clr) begin
      code_d     = ERR_NONE;
      sticky_d   = 1'b0;
      ok_cnt_d   = '0;
      err_cnt_d  = '0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q    <= S_HUNT;
      k_q        <= '0;
      bad_q      <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      sticky_q   <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      bad_q      <= bad_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
      sticky_q   <= sticky_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign in_full    = 1'b0;
  assign frame_ok   = ok_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;
  assign err_sticky = sticky_q;
  assign ok_count   = ok_cnt_q;
  assign err_count  = err_cnt_q;
  assign drop_count = drop_cnt_q;
  assign busy       = (state_q != S_HUNT);

`ifdef DAQ_CHECK_CAPTURE_EN
  logic        cap_v_q, cap_v_d;
  logic [7:0]  cap_i_q, cap_i_d;
  logic [31:0] cap_e_q, cap_e_d;
  logic [31:0] cap_a_q, cap_a_d;
  logic        hit;
  logic [7:0]  hit_idx;
  logic [31:0] hit_exp;

  always_comb begin
    hit     = 1'b0;
    hit_idx = 8'd0;
    hit_exp = 32'd0;
    if (accept) begin
      unique case (state_q)
        S_PAYLOAD: begin
          if (is_head) begin
            hit     = 1'b1;
            hit_idx = 8'hFF;
            hit_exp = exp_word;
          end else if (in_data != exp_word) begin
            hit     = 1'b1;
            hit_idx = 8'(k_q);
            hit_exp = exp_word;
          end
        end
        S_TAIL: begin
          if (!is_tail) begin
            hit     = 1'b1;
            hit_idx = 8'hFF;
            hit_exp = TAIL_WORD;
          end
        end
        default: hit = 1'b0;
      endcase
    end

    cap_v_d = cap_v_q;
    cap_i_d = cap_i_q;
    cap_e_d = cap_e_q;
    cap_a_d = cap_a_q;
    if (clr) begin
      cap_v_d = 1'b0;
      cap_i_d = 8'd0;
      cap_e_d = 32'd0;
      cap_a_d = 32'd0;
    end else if (hit && !cap_v_q) begin
      cap_v_d = 1'b1;
      cap_i_d = hit_idx;
      cap_e_d = hit_exp;
      cap_a_d = in_data;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      cap_v_q <= 1'b0;
      cap_i_q <= 8'd0;
      cap_e_q <= 32'd0;
      cap_a_q <= 32'd0;
    end else begin
      cap_v_q <= cap_v_d;
      cap_i_q <= cap_i_d;
      cap_e_q <= cap_e_d;
      cap_a_q <= cap_a_d;
    end
  end

  assign cap_valid    = cap_v_q;
  assign cap_index    = cap_i_q;
  assign cap_expected = cap_e_q;
  assign cap_actual   = cap_a_q;
`else
  assign cap_valid    = 1'b0;
  assign cap_index    = 8'd0;
  assign cap_expected = 32'd0;
  assign cap_actual   = 32'd0;
`endif

endmodule

// File: tb/tb_daq_frame_checker.sv
// tb_daq_frame_checker: scoreboard bench for daq_frame_checker.
// Frame verdicts queued at stimulus time, popped by a pulse monitor.
module tb_daq_frame_checker;

  localparam int          PW   = 24;
  localparam logic [31:0] HEAD = 32'hAAAAAAAA;
  localparam logic [31:0] TAIL = 32'hF0F0F0F0;

  logic        bus_clk;
  logic        bus_rst_n;
  logic        in_open;
  logic        in_wren;
  logic [31:0] in_data;
  logic        in_full;
  logic        clr;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        err_sticky;
  logic [15:0] ok_count;
  logic [15:0] err_count;
  logic [15:0] drop_count;
  logic        busy;
  logic        cap_valid;
  logic [7:0]  cap_index;
  logic [31:0] cap_expected;
  logic [31:0] cap_actual;

  typedef struct packed {
    logic       ok;
    logic [1:0] code;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_ok, exp_err, exp_drop;

  daq_frame_checker dut (
    .bus_clk     (bus_clk),
    .bus_rst_n   (bus_rst_n),
    .in_open     (in_open),
    .in_wren     (in_wren),
    .in_data     (in_data),
    .in_full     (in_full),
    .clr         (clr),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .err_sticky  (err_sticky),
    .ok_count    (ok_count),
    .err_count   (err_count),
    .drop_count  (drop_count),
    .busy        (busy),
    .cap_valid   (cap_valid),
    .cap_index   (cap_index),
    .cap_expected(cap_expected),
    .cap_actual  (cap_actual)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  always @(negedge bus_clk) begin
    if (bus_rst_n && (frame_ok || frame_err)) begin
      vectors++;
      if (frame_ok && frame_err) begin
        miscompares++;
        $display("FAIL pulse_both ok=%b err=%b required one", frame_ok, frame_err);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected ok=%b err=%b code=%0d required none",
                 frame_ok, frame_err, err_code);
      end else begin
        mon_e = sb.pop_front();
        if (frame_ok !== mon_e.ok ||
            (!mon_e.ok && err_code !== mon_e.code)) begin
          miscompares++;
          $display("FAIL pulse_verdict ok=%b code=%0d required ok=%b code=%0d",
                   frame_ok, err_code, mon_e.ok, mon_e.code);
        end
      end
    end
  end

  function automatic logic [31:0] pw(input int k);
    return 32'((2 * k + 1) * 65536 + (2 * k + 2));
  endfunction

  task automatic put(input logic [31:0] w);
    in_wren = 1'b1;
    in_data = w;
    @(posedge bus_clk);
    #1;
    in_wren = 1'b0;
  endtask

  task automatic push_ok();
    sb.push_back('{ok: 1'b1, code: 2'd0});
    if (exp_ok != 16'hFFFF) exp_ok++;
  endtask

  task automatic push_err(input logic [1:0] c);
    sb.push_back('{ok: 1'b0, code: c});
    if (exp_err != 16'hFFFF) exp_err++;
  endtask

  task automatic send_payload(input int from, input int to);
    for (int k = from; k <= to; k++) put(pw(k));
  endtask

  task automatic send_good();
    put(HEAD);
    send_payload(0, PW - 1);
    put(TAIL);
    push_ok();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge bus_clk);
    #1;
    clr = 1'b0;
    exp_ok = 0; exp_err = 0; exp_drop = 0;
  endtask

  task automatic test_reset();
    bus_rst_n = 1'b0;
    in_open = 1'b0; in_wren = 1'b0; in_data = '0; clr = 1'b0;
    exp_ok = 0; exp_err = 0; exp_drop = 0;
    #12;
    vectors++;
    if ({frame_ok, frame_err, err_code, err_sticky, busy, in_full,
         ok_count, err_count, drop_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs ok=%b err=%b code=%0d st=%b busy=%b full=%b cnt=%h/%h/%h required 0",
               frame_ok, frame_err, err_code, err_sticky, busy, in_full,
               ok_count, err_count, drop_count);
    end
    vectors++;
    if ({cap_valid, cap_index, cap_expected, cap_actual} !== '0) begin
      miscompares++;
      $display("FAIL reset_cap v=%b i=%h e=%h a=%h required 0",
               cap_valid, cap_index, cap_expected, cap_actual);
    end
    @(negedge bus_clk);
    bus_rst_n = 1'b1;
    in_open = 1'b1;
    @(posedge bus_clk);
    #1;
  endtask

  task automatic test_good_frame();
    send_good();
    vectors++;
    if (frame_ok !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL good_timing ok=%b busy=%b required ok=1 busy=0", frame_ok, busy);
    end
    @(negedge bus_clk);
    vectors++;
    if ({ok_count, err_count, drop_count} !== {exp_ok, exp_err, exp_drop}) begin
      miscompares++;
      $display("FAIL good_counts got %h/%h/%h required %h/%h/%h",
               ok_count, err_count, drop_count, exp_ok, exp_err, exp_drop);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) begin
      put(32'h12345678);
      exp_drop++;
    end
    send_good();
    @(negedge bus_clk);
    vectors++;
    if ({ok_count, drop_count} !== {exp_ok, exp_drop}) begin
      miscompares++;
      $display("FAIL drop_counts got ok=%0d drop=%0d required ok=%0d drop=%0d",
               ok_count, drop_count, exp_ok, exp_drop);
    end
  endtask

  task automatic test_payload_err();
    put(HEAD);
    send_payload(0, 4);
    put(32'h0);
    send_payload(6, PW - 1);
    put(TAIL);
    push_err(2'd1);
    @(negedge bus_clk);
    vectors++;
    if (err_code !== 2'd1 || err_sticky !== 1'b1 || err_count !== exp_err) begin
      miscompares++;
      $display("FAIL payload_err code=%0d st=%b errc=%0d required 1 1 %0d",
               err_code, err_sticky, err_count, exp_err);
    end
    vectors++;
`ifdef DAQ_CHECK_CAPTURE_EN
    if (cap_valid !== 1'b1 || cap_index !== 8'd5 ||
        cap_expected !== 32'h000B000C || cap_actual !== 32'h0) begin
      miscompares++;
      $display("FAIL cap_payload v=%b i=%h e=%h a=%h required 1 05 000b000c 0",
               cap_valid, cap_index, cap_expected, cap_actual);
    end
`else
    if ({cap_valid, cap_index, cap_expected, cap_actual} !== '0) begin
      miscompares++;
      $display("FAIL cap_off v=%b i=%h e=%h a=%h required 0",
               cap_valid, cap_index, cap_expected, cap_actual);
    end
`endif
  endtask

  task automatic test_tail_err();
    put(HEAD);
    send_payload(0, PW - 1);
    put(32'hF0F0F0F1);
    push_err(2'd2);
    @(negedge bus_clk);
    vectors++;
    if (err_code !== 2'd2 || err_count !== exp_err) begin
      miscompares++;
      $display("FAIL tail_err code=%0d errc=%0d required 2 %0d",
               err_code, err_count, exp_err);
    end
    send_good();
    @(negedge bus_clk);
    vectors++;
    if (ok_count !== exp_ok) begin
      miscompares++;
      $display("FAIL tail_recover okc=%0d required %0d", ok_count, exp_ok);
    end
`ifdef DAQ_CHECK_CAPTURE_EN
    vectors++;
    if (cap_index !== 8'd5 || cap_actual !== 32'h0) begin
      miscompares++;
      $display("FAIL cap_hold i=%h a=%h required 05 0", cap_index, cap_actual);
    end
`endif
  endtask

  task automatic test_early_head();
    put(HEAD);
    send_payload(0, 9);
    put(HEAD);
    push_err(2'd3);
    send_payload(0, PW - 1);
    put(TAIL);
    push_ok();
    @(negedge bus_clk);
    vectors++;
    if (err_code !== 2'd3 || {ok_count, err_count} !== {exp_ok, exp_err}) begin
      miscompares++;
      $display("FAIL early_head code=%0d okc=%0d errc=%0d required 3 %0d %0d",
               err_code, ok_count, err_count, exp_ok, exp_err);
    end
  endtask

  task automatic test_open_drop();
    do_clr();
    vectors++;
    if ({ok_count, err_count, drop_count, err_code, err_sticky, cap_valid} !== '0) begin
      miscompares++;
      $display("FAIL clr_state cnt=%h/%h/%h code=%0d st=%b cv=%b required 0",
               ok_count, err_count, drop_count, err_code, err_sticky, cap_valid);
    end
    put(HEAD);
    send_payload(0, 7);
    in_open = 1'b0;
    @(posedge bus_clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL close_busy busy=%b required 0", busy);
    end
    in_open = 1'b1;
    send_good();
    @(negedge bus_clk);
    vectors++;
    if ({ok_count, err_count, drop_count, err_sticky} !==
        {exp_ok, exp_err, exp_drop, 1'b0}) begin
      miscompares++;
      $display("FAIL reopen cnt=%0d/%0d/%0d st=%b required %0d/%0d/%0d 0",
               ok_count, err_count, drop_count, err_sticky, exp_ok, exp_err, exp_drop);
    end
  endtask

  task automatic test_saturate();
    do_clr();
    put(HEAD);
    for (int i = 0; i < 65539; i++) begin
      put(HEAD);
      push_err(2'd3);
    end
    send_payload(0, PW - 1);
    put(TAIL);
    push_ok();
    @(negedge bus_clk);
    vectors++;
    if (err_count !== 16'hFFFF || exp_err !== 16'hFFFF || ok_count !== exp_ok) begin
      miscompares++;
      $display("FAIL saturate errc=%h okc=%0d required ffff %0d",
               err_count, ok_count, exp_ok);
    end
  endtask

  task automatic test_clr_collide();
    put(HEAD);
    send_payload(0, PW - 1);
    clr = 1'b1;
    put(TAIL);
    clr = 1'b0;
    sb.push_back('{ok: 1'b1, code: 2'd0});
    exp_ok = 0; exp_err = 0; exp_drop = 0;
    vectors++;
    if (frame_ok !== 1'b1 || ok_count !== 16'd0 || err_count !== 16'd0) begin
      miscompares++;
      $display("FAIL clr_collide ok=%b okc=%0d errc=%0d required 1 0 0",
               frame_ok, ok_count, err_count);
    end
    send_good();
    @(negedge bus_clk);
    vectors++;
    if (ok_count !== exp_ok) begin
      miscompares++;
      $display("FAIL clr_after okc=%0d required %0d", ok_count, exp_ok);
    end
  endtask

  task automatic test_async_reset();
    put(32'h0);
    exp_drop++;
    put(HEAD);
    send_payload(0, 3);
    #2;
    bus_rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, ok_count, err_count, drop_count, err_code, err_sticky} !== '0) begin
      miscompares++;
      $display("FAIL async_reset busy=%b cnt=%h/%h/%h code=%0d st=%b required 0",
               busy, ok_count, err_count, drop_count, err_code, err_sticky);
    end
    exp_ok = 0; exp_err = 0; exp_drop = 0;
    @(negedge bus_clk);
    bus_rst_n = 1'b1;
    send_good();
    @(negedge bus_clk);
    vectors++;
    if ({ok_count, err_count, drop_count} !== {exp_ok, exp_err, exp_drop}) begin
      miscompares++;
      $display("FAIL post_reset cnt=%0d/%0d/%0d required %0d/%0d/%0d",
               ok_count, err_count, drop_count, exp_ok, exp_err, exp_drop);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_drop();
    test_payload_err();
    test_tail_err();
    test_early_head();
    test_open_drop();
    test_saturate();
    test_clr_collide();
    test_async_reset();
    repeat (3) @(negedge bus_clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
